perf_event_counter_bank: RTL and testbench
==========================================

Name: perf_event_counter_bank

Overview:
- Parametrised successor to the per-event counter array.
- Provides NUM_EVENTS independent event counters with:
  - a per-channel enable mask;
  - wrap or saturate mode;
  - sticky overflow flags;
  - an atomic snapshot-and-clear with a valid/ready handshake.
- Sits between the CPU performance-event bitmap and the DMA packing stage. The packed snapshot feeds the DMA data word directly.

Parameters:
- NUM_EVENTS, 115, number of event channels (width of the input bitmap).
- COUNTER_WIDTH, 7, bits per counter.
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to zero.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- performance_events  input  NUM_EVENTS  event bitmap, one bit per channel per cycle.
- event_enable  input  NUM_EVENTS  per-channel count enable mask.
- snapshot_req  input  1  request to capture and clear all counters (level, sampled each cycle).
- snapshot_valid  output  1  snapshot data is valid.
- snapshot_ready  input  1  consumer accepts the snapshot.
- snapshot_counters  output  NUM_EVENTS*COUNTER_WIDTH  captured counters; channel i at [i*COUNTER_WIDTH +: COUNTER_WIDTH].
- snapshot_overflow  output  NUM_EVENTS  captured sticky overflow flags.
- snapshot_missed  output  1  one-cycle pulse: a request was dropped.
- live_counters  output  NUM_EVENTS*COUNTER_WIDTH  current counter values, same packing.

Behaviour:
- Reset (async, rst=1): all counters 0, overflow flags 0, snapshot registers 0, snapshot_valid 0, snapshot_missed 0, FSM to IDLE.
  - Takes effect immediately, including mid-HOLD: valid drops without a handshake.
- Increment: inc[i] = performance_events[i] & event_enable[i]; applied every cycle.
- Overflow:
  - If inc[i]=1 and counter[i] is all-ones, ovf[i] is set.
  - ovf[i] stays set until a snapshot clears it.
  - Counter result is all-ones if SATURATE=1, or 0 if SATURATE=0.
- live_counters reflects the registered counters (1-cycle latency from the event).
- FSM states: IDLE, HOLD.
- IDLE, snapshot_req=1 (capture):
  - snapshot_counters and snapshot_overflow load the pre-update register values.
  - Counters load inc[i] (0 or 1), so this cycle's events are not lost.
  - ovf flags clear.
  - Go to HOLD; snapshot_valid=1 from the next cycle.
- HOLD:
  - snapshot_counters, snapshot_overflow and snapshot_valid stay stable until the handshake (valid & ready).
  - Counters keep counting normally.
- HOLD, snapshot_ready=1, snapshot_req=0: handshake completes; next cycle valid=0, state IDLE.
- HOLD, snapshot_ready=1, snapshot_req=1 (back-to-back): handshake plus a new capture in the same cycle; stay in HOLD, valid stays 1, new data next cycle.
- HOLD, snapshot_ready=0, snapshot_req=1: request dropped; snapshot_missed=1 next cycle for one cycle; counters are not cleared.
- IDLE, snapshot_ready=1 with no valid: ignored.
- Enable mask change: takes effect the same cycle; counts already accumulated are kept.
- COUNTER_WIDTH=1 is legal: overflow occurs on the second event.
- Synthesis checks: NUM_EVENTS >= 1, COUNTER_WIDTH >= 1.

Decomposition:
- Package perf_counter_pkg holds:
  - snapshot FSM state enum (IDLE, HOLD);
  - mode constants (MODE_WRAP=0, MODE_SATURATE=1);
  - helper function for the packed-slice index.
- Sub-module perf_event_counter, one channel:
  - inputs: clk, rst, inc, clear_load, SATURATE/COUNTER_WIDTH parameters;
  - outputs: count, ovf;
  - instantiated NUM_EVENTS times in a generate loop.
- The top level owns the FSM, snapshot registers and packing.

Test Plan (NUM_EVENTS=4, COUNTER_WIDTH=3 unless noted):
1. Reset then enable=4'b1111, events=4'b0101 for 5 cycles -> live ch0=5, ch1=0, ch2=5, ch3=0; overflow=0.
2. SATURATE=1, ch0 event 10 cycles -> ch0 holds 7, ovf[0]=1. Same with SATURATE=0 -> ch0=2 (10 mod 8), ovf[0]=1.
3. ch0 at 4, events[0]=1 and snapshot_req for one cycle -> next cycle snapshot_valid=1, snapshot ch0=4, live ch0=1; ready held 0 for 3 cycles -> data stable; ready=1 -> valid=0 next cycle.
4. In HOLD with ready=0, pulse snapshot_req -> snapshot_missed high exactly 1 cycle, live counters not cleared. Then req=1 with ready=1 -> back-to-back: valid stays 1, new snapshot data.
5. enable=4'b0010, events=4'b1111 for 3 cycles -> only ch1=3. Then assert rst mid-HOLD -> snapshot_valid=0 and all counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/perf_counter_pkg.sv
// Shared types and helpers for the performance event counter bank.
package perf_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // Low bit of channel idx inside a packed per-channel vector.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/perf_event_counter_bank_if.sv
// Snapshot handshake bundle between the counter bank and its consumer.
interface perf_event_counter_bank_if #(
  parameter int NUM_EVENTS    = 115,
  parameter int COUNTER_WIDTH = 7
);
  logic                                snapshot_req;
  logic                                snapshot_valid;
  logic                                snapshot_ready;
  logic [NUM_EVENTS*COUNTER_WIDTH-1:0] snapshot_counters;
  logic [NUM_EVENTS-1:0]               snapshot_overflow;
  logic                                snapshot_missed;

  modport master (
    input  snapshot_req, snapshot_ready,
    output snapshot_valid, snapshot_counters, snapshot_overflow, snapshot_missed
  );

  modport slave (
    output snapshot_req, snapshot_ready,
    input  snapshot_valid, snapshot_counters, snapshot_overflow, snapshot_missed
  );
endinterface

// File: rtl/perf_event_counter.sv
// One event counter channel with sticky overflow and snapshot clear-load.
import perf_counter_pkg::*;

module perf_event_counter #(
  parameter int COUNTER_WIDTH = 7,
  parameter int SATURATE      = MODE_SATURATE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clear_load,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     ovf
);

  localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear_load) begin
      // The capture cycle's own event seeds the fresh count.
      count <= inc ? ONE : '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == ALL_ONES) begin
        ovf   <= 1'b1;
        count <= (SATURATE == MODE_SATURATE) ? ALL_ONES : '0;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/perf_event_counter_bank.sv
// Bank of masked event counters with an atomic snapshot-and-clear handshake.
import perf_counter_pkg::*;

module perf_event_counter_bank #(
  parameter int NUM_EVENTS    = 115,
  parameter int COUNTER_WIDTH = 7,
  parameter int SATURATE      = MODE_SATURATE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_EVENTS-1:0]               performance_events,
  input  logic [NUM_EVENTS-1:0]               event_enable,
  output logic [NUM_EVENTS*COUNTER_WIDTH-1:0] live_counters,
  perf_event_counter_bank_if.master           snap
);

  generate
    if (NUM_EVENTS < 1)    begin : g_chk_ne $error("NUM_EVENTS must be >= 1");    end
    if (COUNTER_WIDTH < 1) begin : g_chk_cw $error("COUNTER_WIDTH must be >= 1"); end
  endgenerate

  logic [NUM_EVENTS-1:0] inc;
  logic [NUM_EVENTS-1:0] ovf;
  snap_state_e           state_q, state_d;
  logic                  capture;
  logic                  missed_d;

  assign inc = performance_events & event_enable;

  genvar i;
  generate
    for (i = 0; i < NUM_EVENTS; i++) begin : g_ch
      perf_event_counter #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .SATURATE      (SATURATE)
      ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc[i]),
        .clear_load (capture),
        .count      (live_counters[slice_lo(i, COUNTER_WIDTH) +: COUNTER_WIDTH]),
        .ovf        (ovf[i])
      );
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    missed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap.snapshot_req) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (snap.snapshot_ready) begin
          // Handshake; a simultaneous request re-captures and stays in HOLD.
          if (snap.snapshot_req) capture = 1'b1;
          else                   state_d = IDLE;
        end else if (snap.snapshot_req) begin
          missed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                <= IDLE;
      snap.snapshot_counters <= '0;
      snap.snapshot_overflow <= '0;
      snap.snapshot_missed   <= 1'b0;
    end else begin
      state_q              <= state_d;
      snap.snapshot_missed <= missed_d;
      if (capture) begin
        snap.snapshot_counters <= live_counters;
        snap.snapshot_overflow <= ovf;
      end
    end
  end

  assign snap.snapshot_valid = (state_q == HOLD);

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Directed bench: saturating, wrapping and 1-bit-wide banks driven in lockstep.
module tb_perf_event_counter_bank;

  localparam int NE = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NE-1:0] ev  = '0;
  logic [NE-1:0] en  = '0;
  logic [NE*CW-1:0] live_sat, live_wrap;
  logic [NE-1:0]    live_w1;

  int n_chk  = 0;
  int n_pass = 0;

  perf_event_counter_bank_if #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW)) if_sat  ();
  perf_event_counter_bank_if #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW)) if_wrap ();
  perf_event_counter_bank_if #(.NUM_EVENTS(NE), .COUNTER_WIDTH(1))  if_w1   ();

  perf_event_counter_bank #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .performance_events(ev), .event_enable(en),
    .live_counters(live_sat), .snap(if_sat.master));
  perf_event_counter_bank #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .performance_events(ev), .event_enable(en),
    .live_counters(live_wrap), .snap(if_wrap.master));
  perf_event_counter_bank #(.NUM_EVENTS(NE), .COUNTER_WIDTH(1), .SATURATE(1)) u_w1 (
    .clk(clk), .rst(rst), .performance_events(ev), .event_enable(en),
    .live_counters(live_w1), .snap(if_w1.master));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [CW-1:0] ch(input logic [NE*CW-1:0] v, input int i);
    return v[i*CW +: CW];
  endfunction

  task automatic set_hs(input logic req, input logic rdy);
    if_sat.snapshot_req  = req; if_sat.snapshot_ready  = rdy;
    if_wrap.snapshot_req = req; if_wrap.snapshot_ready = rdy;
    if_w1.snapshot_req   = req; if_w1.snapshot_ready   = rdy;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    set_hs(1'b0, 1'b0);
    tick(2);
    chk("rst_live",   live_sat, 0);
    chk("rst_valid",  if_sat.snapshot_valid, 0);
    chk("rst_missed", if_sat.snapshot_missed, 0);
    chk("rst_snap",   if_sat.snapshot_counters, 0);
    rst = 1'b0;

    // Counting under a full enable mask
    en = 4'b1111; ev = 4'b0101;
    tick(5);
    chk("t1_ch0", ch(live_sat, 0), 5);
    chk("t1_ch1", ch(live_sat, 1), 0);
    chk("t1_ch2", ch(live_sat, 2), 5);
    chk("t1_ch3", ch(live_sat, 3), 0);
    ev = 4'b0000; set_hs(1'b1, 1'b0);
    tick();
    chk("t1_valid",    if_sat.snapshot_valid, 1);
    chk("t1_snap_ch0", ch(if_sat.snapshot_counters, 0), 5);
    chk("t1_snap_ch2", ch(if_sat.snapshot_counters, 2), 5);
    chk("t1_ovf",      if_sat.snapshot_overflow, 4'b0000);
    chk("t1_w1_ovf",   if_w1.snapshot_overflow, 4'b0101);
    chk("t1_cleared",  live_sat, 0);
    set_hs(1'b0, 1'b1);
    tick();
    chk("t1_hs_valid", if_sat.snapshot_valid, 0);
    set_hs(1'b0, 1'b0);

    // Saturate vs wrap with sticky overflow
    ev = 4'b0001;
    tick(10);
    chk("t2_sat_ch0",  ch(live_sat, 0), 7);
    chk("t2_wrap_ch0", ch(live_wrap, 0), 2);
    ev = 4'b0000; set_hs(1'b1, 1'b0);
    tick();
    chk("t2_sat_ovf",   if_sat.snapshot_overflow, 4'b0001);
    chk("t2_wrap_ovf",  if_wrap.snapshot_overflow, 4'b0001);
    chk("t2_sat_snap",  ch(if_sat.snapshot_counters, 0), 7);
    chk("t2_wrap_snap", ch(if_wrap.snapshot_counters, 0), 2);
    set_hs(1'b0, 1'b1);
    tick();
    set_hs(1'b0, 1'b0);

    // Capture with a same-cycle event, then hold until ready
    ev = 4'b0001;
    tick(4);
    chk("t3_pre_ch0", ch(live_sat, 0), 4);
    set_hs(1'b1, 1'b0);
    tick();
    chk("t3_valid",     if_sat.snapshot_valid, 1);
    chk("t3_snap_ch0",  ch(if_sat.snapshot_counters, 0), 4);
    chk("t3_live_ch0",  ch(live_sat, 0), 1);
    chk("t3_ovf_clear", if_sat.snapshot_overflow, 4'b0000);
    ev = 4'b0000; set_hs(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_valid", if_sat.snapshot_valid, 1);
      chk("t3_hold_snap",  ch(if_sat.snapshot_counters, 0), 4);
    end
    set_hs(1'b0, 1'b1);
    tick();
    chk("t3_drop_valid", if_sat.snapshot_valid, 0);
    tick();
    chk("t3_idle_ready", if_sat.snapshot_valid, 0);
    set_hs(1'b0, 1'b0);

    // Dropped request in HOLD, then back-to-back capture
    ev = 4'b0001;
    tick(2);
    set_hs(1'b1, 1'b0);
    tick();
    chk("t4_snap_ch0", ch(if_sat.snapshot_counters, 0), 3);
    chk("t4_live_ch0", ch(live_sat, 0), 1);
    set_hs(1'b1, 1'b0);
    tick();
    chk("t4_missed",      if_sat.snapshot_missed, 1);
    chk("t4_no_clear",    ch(live_sat, 0), 2);
    chk("t4_snap_stable", ch(if_sat.snapshot_counters, 0), 3);
    ev = 4'b0000; set_hs(1'b0, 1'b0);
    tick();
    chk("t4_missed_pulse", if_sat.snapshot_missed, 0);
    chk("t4_still_valid",  if_sat.snapshot_valid, 1);
    set_hs(1'b1, 1'b1);
    tick();
    chk("t4_b2b_valid", if_sat.snapshot_valid, 1);
    chk("t4_b2b_snap",  ch(if_sat.snapshot_counters, 0), 2);
    chk("t4_b2b_live",  ch(live_sat, 0), 0);
    set_hs(1'b0, 1'b1);
    tick();
    chk("t4_end_valid", if_sat.snapshot_valid, 0);
    set_hs(1'b0, 1'b0);

    // Enable mask, then async reset during HOLD
    en = 4'b0010; ev = 4'b1111;
    tick(3);
    chk("t5_mask_ch0", ch(live_sat, 0), 0);
    chk("t5_mask_ch1", ch(live_sat, 1), 3);
    chk("t5_mask_ch2", ch(live_sat, 2), 0);
    set_hs(1'b1, 1'b0);
    tick();
    set_hs(1'b0, 1'b0);
    tick();
    chk("t5_snap_ch1", ch(if_sat.snapshot_counters, 1), 3);
    chk("t5_live_ch1", ch(live_sat, 1), 2);
    chk("t5_hold",     if_sat.snapshot_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", if_sat.snapshot_valid, 0);
    chk("t5_rst_live",  live_sat, 0);
    chk("t5_rst_snap",  if_sat.snapshot_counters, 0);
    chk("t5_rst_wrap",  if_wrap.snapshot_valid, 0);
    ev = 4'b0000; en = 4'b1111;
    tick();
    rst = 1'b0;

    // One-bit counters overflow on the second event
    ev = 4'b0001;
    tick();
    ev = 4'b0000; set_hs(1'b1, 1'b0);
    tick();
    chk("w1_one_ovf", if_w1.snapshot_overflow, 4'b0000);
    chk("w1_one_cnt", if_w1.snapshot_counters, 4'b0001);
    set_hs(1'b0, 1'b1);
    tick();
    set_hs(1'b0, 1'b0);
    ev = 4'b0001;
    tick(2);
    ev = 4'b0000; set_hs(1'b1, 1'b0);
    tick();
    chk("w1_two_ovf", if_w1.snapshot_overflow, 4'b0001);
    chk("w1_two_cnt", if_w1.snapshot_counters, 4'b0001);
    set_hs(1'b0, 1'b1);
    tick();
    set_hs(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
